// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters, plus EX-stage mispredict/restore reporting.
// Latency: lookup and mispredict are combinational; table updates land on the rising CLK edge. No backpressure, one resolve per branch.
// Optional statistics counters are enabled with `define BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int IDXW  = 3,
    parameter int WORDW = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WORDW-1:0] lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [WORDW-1:0] pred_target,
    input  logic             resolve_en,
    input  logic [WORDW-1:0] resolve_pc,
    input  logic             resolve_taken,
    input  logic [WORDW-1:0] resolve_target,
    input  logic             resolve_pred_taken,
    input  logic [WORDW-1:0] resolve_pred_target,
    output logic             mispredict,
    output logic [WORDW-1:0] restore_pc,
    output logic             restore_is_branch,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    localparam int ENTRIES = 1 << IDXW;
    localparam int TAGW    = WORDW - IDXW - 2;
    localparam logic [WORDW-1:0] PC_STEP = WORDW'(4);

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic             valid_q  [ENTRIES];
    logic [TAGW-1:0]  tag_q    [ENTRIES];
    logic [WORDW-1:0] target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDXW-1:0] rs_idx;
    logic [TAGW-1:0] rs_tag;
    logic            rs_hit;
    logic [1:0]      rs_ctr;
    logic [1:0]      ctr_inc;
    logic [1:0]      ctr_dec;

    assign lk_idx = lookup_pc[IDXW+1:2];
    assign lk_tag = lookup_pc[WORDW-1:IDXW+2];
    assign rs_idx = resolve_pc[IDXW+1:2];
    assign rs_tag = resolve_pc[WORDW-1:IDXW+2];

    // Lookup reads the registered table only; a same-cycle update is not bypassed.
    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && ctr_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_STEP;

    assign mispredict = resolve_en &&
                        ((resolve_pred_taken != resolve_taken) ||
                         (resolve_taken && (resolve_pred_target != resolve_target)));
    assign restore_pc        = resolve_taken ? resolve_target : resolve_pc + PC_STEP;
    assign restore_is_branch = resolve_taken;

    assign rs_hit  = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
    assign rs_ctr  = ctr_q[rs_idx];
    assign ctr_inc = (rs_ctr == CTR_ST)  ? CTR_ST  : rs_ctr + 2'd1;
    assign ctr_dec = (rs_ctr == CTR_SNT) ? CTR_SNT : rs_ctr - 2'd1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (resolve_en) begin
            if (rs_hit) begin
                if (resolve_taken) begin
                    ctr_q[rs_idx]    <= ctr_inc;
                    target_q[rs_idx] <= resolve_target;
                end else begin
                    ctr_q[rs_idx] <= ctr_dec;
                end
            end else if (resolve_taken) begin
                // Taken miss replaces whatever aliased into this slot; not-taken misses never allocate.
                valid_q[rs_idx]  <= 1'b1;
                tag_q[rs_idx]    <= rs_tag;
                target_q[rs_idx] <= resolve_target;
                ctr_q[rs_idx]    <= CTR_WT;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (resolve_en && (branches_q != '1)) begin
                branches_q <= branches_q + 32'd1;
            end
            if (mispredict && (mispredicts_q != '1)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
